// File: rtl/poly_diff_pkg.sv
// Shared types and helpers for the forward-difference polynomial engine.
package poly_diff_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DIFF,
    RUN
  } state_t;

  localparam int DEG_MAX = 6;

  // Cycles from the accept edge to the first RUN cycle (Horner sampling plus table build).
  function automatic int first_result_latency(input int deg);
    return deg * (deg + 2);
  endfunction

endpackage

// File: rtl/poly_horner_unit.sv
// Horner evaluator: one multiply-by-small-j and one add per cycle, DEG cycles per point.
module poly_horner_unit
  import poly_diff_pkg::*;
#(
  parameter int DEG = 3,
  parameter int CW  = 8,
  parameter int YW  = 40,
  parameter int JW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [JW-1:0]         j,
  input  logic [(DEG+1)*CW-1:0] coef,
  output logic                  done,
  output logic [YW-1:0]         result
);

  logic [JW-1:0] k;
  logic [YW-1:0] acc;
  logic [YW-1:0] base;
  logic [YW-1:0] product;
  logic [CW-1:0] c_k;
  logic [CW-1:0] c_top;

  // The first step of each point seeds from c[DEG] directly, so no separate load cycle is needed.
  always_comb begin
    c_k     = coef[int'(k)*CW +: CW];
    c_top   = coef[DEG*CW +: CW];
    base    = (k == JW'(DEG - 1)) ? {{(YW-CW){c_top[CW-1]}}, c_top} : acc;
    product = base * YW'(j);
    result  = product + {{(YW-CW){c_k[CW-1]}}, c_k};
    done    = en && (k == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k   <= JW'(DEG - 1);
      acc <= '0;
    end else if (en) begin
      acc <= result;
      if (k == '0) begin
        k <= JW'(DEG - 1);
      end else begin
        k <= k - JW'(1);
      end
    end
  end

endmodule

// File: rtl/poly_diff_engine.sv
// Forward-difference polynomial evaluator: samples p(0..DEG) with Horner, differences
// the table in place, then steps p(i) with additions only.
module poly_diff_engine
  import poly_diff_pkg::*;
#(
  parameter int DEG = 3,
  parameter int CW  = 8,
  parameter int XW  = 8,
  parameter int YW  = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [(DEG+1)*CW-1:0] coef,
  input  logic [XW-1:0]         x,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [YW-1:0]         y,
  output logic [XW-1:0]         out_idx,
  output logic                  out_last
);

  localparam int JW = $clog2(DEG + 1);

  state_t state;
  state_t state_next;

  logic [(DEG+1)*CW-1:0] coef_r;
  logic [XW-1:0]         x_r;
  logic                  mode_r;
  logic [XW-1:0]         cnt;
  logic [JW-1:0]         j_cnt;
  logic [JW-1:0]         lvl;
  logic [YW-1:0]         d [0:DEG];

  logic                  h_en;
  logic                  h_done;
  logic [YW-1:0]         h_result;

  logic                  accept;
  logic                  advance;
  logic                  finish;

  poly_horner_unit #(
    .DEG (DEG),
    .CW  (CW),
    .YW  (YW),
    .JW  (JW)
  ) u_horner (
    .clk    (clk),
    .rst    (rst),
    .en     (h_en),
    .j      (j_cnt),
    .coef   (coef_r),
    .done   (h_done),
    .result (h_result)
  );

  always_comb begin
    h_en    = (state == SAMPLE);
    accept  = (state == IDLE) && in_valid;
    advance = (state == RUN) && (!out_valid || out_ready) && !out_last;
    finish  = out_valid && out_ready && out_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SAMPLE;
      SAMPLE:  if (h_done && (j_cnt == JW'(DEG))) state_next = DIFF;
      DIFF:    if (lvl == JW'(DEG)) state_next = RUN;
      RUN:     if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_last  = (state == RUN) && (cnt == x_r);
    out_valid = (state == RUN) && (mode_r || out_last);
    y         = d[0];
    out_idx   = cnt;
  end

  // Stalls need no explicit hold: the table only moves on advance, which backpressure blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_r <= '0;
      x_r    <= '0;
      mode_r <= 1'b0;
      cnt    <= '0;
      j_cnt  <= '0;
      lvl    <= '0;
      for (int m = 0; m <= DEG; m++) begin
        d[m] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            coef_r <= coef;
            x_r    <= x;
            mode_r <= mode;
            cnt    <= '0;
            j_cnt  <= '0;
            lvl    <= JW'(1);
          end
        end
        SAMPLE: begin
          if (h_done) begin
            for (int m = 0; m <= DEG; m++) begin
              if (j_cnt == JW'(m)) begin
                d[m] <= h_result;
              end
            end
            j_cnt <= j_cnt + JW'(1);
          end
        end
        DIFF: begin
          for (int m = 1; m <= DEG; m++) begin
            if (JW'(m) >= lvl) begin
              d[m] <= d[m] - d[m-1];
            end
          end
          lvl <= lvl + JW'(1);
        end
        RUN: begin
          if (advance) begin
            for (int k = 0; k < DEG; k++) begin
              d[k] <= d[k] + d[k+1];
            end
            cnt <= cnt + XW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/poly_diff_engine.md
Name: poly_diff_engine

Overview:
- Parametrised forward-difference polynomial evaluator for p(i) = sum c[k]*i^k, with k = 0..DEG and i = 0..x.
- Initialisation is general for any degree. It evaluates p(0..DEG) by Horner, then builds the difference table in place, then steps it by additions only.
- Has a valid/ready request port and a valid/ready result port with backpressure.
- Two modes: single (emit p(x) only) and stream (emit p(0)..p(x), one per handshake).

Parameters:
- DEG, 3, polynomial degree; legal range 1..6.
- CW, 8, coefficient width; coefficients are signed two's complement.
- XW, 8, width of the evaluation point x; x is unsigned.
- YW, 40, width of the result and of all internal datapath registers; signed, arithmetic is modulo 2^YW.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  high in IDLE only.
- coef  in  (DEG+1)*CW  packed coefficients; c[k] = coef[k*CW +: CW].
- x  in  XW  final evaluation point.
- mode  in  1  0 = single, 1 = stream.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- y  out  YW  p(out_idx) mod 2^YW, signed.
- out_idx  out  XW  index i of the current y.
- out_last  out  1  high when out_idx == x of the latched request.

Behaviour:
- Reset values: state = IDLE; in_ready = 1; out_valid = 0; out_last = 0; y = 0; out_idx = 0. All table registers d[0..DEG] = 0.
- Reset mid-operation aborts the request immediately; no partial result is emitted.
- Accept: in IDLE, a cycle with in_valid high latches coef, x and mode, then enters SAMPLE. in_valid while not IDLE is ignored; nothing is queued.
- SAMPLE, DEG*(DEG+1) cycles:
  - For j = 0..DEG: Horner evaluation, DEG cycles per j.
  - acc starts at sext(c[DEG]); each cycle acc = acc*j + sext(c[k]) for k = DEG-1 down to 0.
  - The result is written to d[j].
- DIFF, DEG cycles:
  - At level l = 1..DEG, in one cycle, d[m] = d[m] - d[m-1] for all m >= l, using pre-cycle values.
  - Afterwards d[k] = delta^k p(0).
- RUN:
  - cnt starts at 0; y = d[0]; out_idx = cnt; out_last = (cnt == x_r).
  - out_valid = mode_r | out_last.
  - Advance when (!out_valid | out_ready) & !out_last: all d[k] += d[k+1] for k < DEG simultaneously (old values), and cnt += 1.
  - If out_valid & out_ready & out_last, go to IDLE. in_ready rises the next cycle, so back-to-back requests have a one-cycle gap.
- Backpressure: while out_valid & !out_ready, y, out_idx, out_last and all d[k] are held stable.
- Latency:
  - First out_valid is exactly DEG*(DEG+2) cycles after the accept edge in stream mode, or DEG*(DEG+2) + x cycles in single mode, assuming no stalls.
  - For DEG = 3 this is 15 and 15 + x.
- x = 0: the first RUN cycle already has out_last = 1 and out_valid = 1 in both modes.
- x = 2^XW - 1: cnt must not wrap. cnt is XW bits and stops at x_r.
- Width: all table and Horner arithmetic is YW bits, wrapping; no saturation, no overflow flag. Defaults cover |p| < 2^39 for every legal input.

Decomposition:
- Package poly_diff_pkg:
  - state enum {IDLE, SAMPLE, DIFF, RUN};
  - DEG_MAX = 6;
  - function first_result_latency(DEG) = DEG*(DEG+2).
- Sub-module poly_horner_unit:
  - holds the accumulator and the k countdown;
  - multiplies by a small constant j (≤ DEG) with a YW-bit datapath;
  - asserts done after DEG cycles.
- The difference table and the FSM stay in poly_diff_engine.

Test Plan:
1. Cubic, single: DEG = 3, c = {0, 0, 0, 1} (c3 = 1), x = 5, mode = 0. Required: exactly one result, out_valid 20 cycles after accept, y = 125, out_idx = 5, out_last = 1.
2. Constant, x = 0: c = {7, 0, 0, 0} (c0 = 7), x = 0. Required: out_valid at cycle 15, y = 7, out_last = 1; in_ready = 1 on the cycle after the handshake.
3. Stream with negative coefficients: c3 = 2, c2 = -3, c1 = 1, c0 = 4, x = 3, mode = 1, out_ready = 1. Required: y = 4, 4, 10, 34 with out_idx 0..3 on consecutive cycles from cycle 15; out_last only on the last.
4. Backpressure: scenario 3 with out_ready low for 5 cycles while out_idx = 1. Required: y = 4 and out_idx = 1 held stable, no skip or duplicate, then 10 and 34.
5. Extremes: all c = -128, x = 255, single mode. Required: y = -2130771968 (sign-extended to 40 bits), at cycle 270.
6. Reset and ignored requests: in_valid pulsed during SAMPLE (ignored, in_ready = 0). Then rst asserted mid-RUN: required out_valid = 0 and in_ready = 1 after release, and a new request from scenario 1 returns y = 125.
